// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: state encoding, anode-off constant and round-robin digit picker
// shared by the 4-digit scan controller.
package digit_scan_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

   localparam logic [3:0] ANODE_OFF = 4'b1111;

   // First set bit strictly after cur, wrapping 3->0; cur itself is the last candidate.
   function automatic logic [1:0] next_set_bit(input logic [3:0] mask, input logic [1:0] cur);
      next_set_bit = cur;
      for (int k = 4; k >= 1; k--)
         if (mask[cur + 2'(k)]) next_set_bit = cur + 2'(k);
   endfunction

endpackage

// File: rtl/dec2_4_n.sv
// dec2_4_n: 2-to-4 decoder with active-low outputs and active-low enable.
module dec2_4_n
   import digit_scan_pkg::*;
(
   input  logic [1:0] i_sel,
   input  logic       i_en_n,
   output logic [3:0] o_an_n
);

   assign o_an_n = i_en_n ? ANODE_OFF : ~(4'b0001 << i_sel);

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit common-anode scan controller with dwell, blanking and digit masking.
// Optional DIGIT_SCAN_BRIGHT_EN adds a duty input gating the anode with a 4-bit phase counter.
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int DWELL_W   = 16,
   parameter int BLANK_CYC = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic [3:0]         i_digit_mask,
`ifdef DIGIT_SCAN_BRIGHT_EN
   input  logic [3:0]         i_duty,
`endif
   output logic [1:0]         o_sel,
   output logic [3:0]         o_an_n,
   output logic               o_tick,
   output logic               o_frame_done
);

   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYC - 1);

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_sel, w_sel_nxt, w_pick;
   logic [DWELL_W-1:0] r_cnt, w_cnt_nxt, w_dwell_ld;
   logic [BW-1:0]      r_bcnt, w_bcnt_nxt;
   logic               r_tick, r_frame, w_tick_nxt, w_frame_nxt, w_dec_en_n;
   logic [3:0]         r_an_n, w_an;

   // From IDLE, searching after index 3 yields the lowest set bit.
   assign w_pick     = next_set_bit(i_digit_mask, (r_state == IDLE) ? 2'd3 : r_sel);
   assign w_dwell_ld = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_bcnt_nxt  = r_bcnt;
      w_tick_nxt  = 1'b0;
      w_frame_nxt = 1'b0;
      if (!i_en) begin
         w_state_nxt = IDLE;
         w_sel_nxt   = 2'd0;
         w_cnt_nxt   = '0;
         w_bcnt_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = (i_digit_mask != 4'd0) ? SHOW : BLANK;
               w_sel_nxt   = (i_digit_mask != 4'd0) ? w_pick : r_sel;
               w_cnt_nxt   = w_dwell_ld;
               w_bcnt_nxt  = BLANK_LD;
               w_tick_nxt  = i_digit_mask != 4'd0;
            end
            SHOW: begin
               w_state_nxt = (r_cnt == '0) ? BLANK : SHOW;
               w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - DWELL_W'(1);
               w_bcnt_nxt  = BLANK_LD;
            end
            BLANK: begin
               if (r_bcnt != '0) w_bcnt_nxt = r_bcnt - BW'(1);
               else if (i_digit_mask != 4'd0) begin
                  w_state_nxt = SHOW;
                  w_sel_nxt   = w_pick;
                  w_cnt_nxt   = w_dwell_ld;
                  w_tick_nxt  = 1'b1;
                  w_frame_nxt = w_pick <= r_sel;
               end else w_bcnt_nxt = BLANK_LD;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

`ifdef DIGIT_SCAN_BRIGHT_EN
   logic [3:0] r_phase;
   always_ff @(posedge clk) r_phase <= rst ? 4'd0 : r_phase + 4'd1;
   // Decoder looks at next-cycle values so the gated anode lines up with the registered state.
   assign w_dec_en_n = (w_state_nxt != SHOW) || ((r_phase + 4'd1) >= i_duty);
`else
   assign w_dec_en_n = w_state_nxt != SHOW;
`endif

   dec2_4_n u_dec (
      .i_sel  (w_sel_nxt),
      .i_en_n (w_dec_en_n),
      .o_an_n (w_an)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= 2'd0;
         r_an_n  <= ANODE_OFF;
         r_tick  <= 1'b0;
         r_frame <= 1'b0;
         r_cnt   <= '0;
         r_bcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_an_n  <= w_an;
         r_tick  <= w_tick_nxt;
         r_frame <= w_frame_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bcnt  <= w_bcnt_nxt;
      end
   end

   assign o_sel        = r_sel;
   assign o_an_n       = r_an_n;
   assign o_tick       = r_tick;
   assign o_frame_done = r_frame;

endmodule
